// File: rtl/mips_pkg.sv
// Shared encodings and constants for the MIPS execute stage.
// Holds the ALUOp and funct codes, the EX FSM states and the default datapath widths.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_mult_iter.sv
// Iterative signed multiplier: one shift-add step per cycle, MULT_CYCLES steps.
// The final step subtracts the multiplicand so the product is two's complement.
module ex_mult_iter #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic                           i_hold,
    input  logic                           i_abort,
    input  logic [DATA_W-1:0]              i_a,
    input  logic [DATA_W-1:0]              i_b,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [$clog2(MULT_CYCLES)-1:0] o_count,
    output logic [2*DATA_W-1:0]            o_product
);

    localparam int CNT_W = $clog2(MULT_CYCLES);

    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W:0]   r_mcand;
    logic [DATA_W:0]   r_acc;
    logic [DATA_W-1:0] r_mplier;

    logic              w_last;
    logic [DATA_W:0]   w_addend;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_acc_next;
    logic [DATA_W-1:0] w_mplier_next;

    assign w_last        = (r_count == CNT_W'(MULT_CYCLES - 1));
    // Sign bit of the multiplier carries weight -2^(N-1), hence the subtract on the last step.
    assign w_addend      = !r_mplier[0] ? '0 : (w_last ? -r_mcand : r_mcand);
    assign w_sum         = r_acc + w_addend;
    assign w_acc_next    = {w_sum[DATA_W], w_sum[DATA_W:1]};
    assign w_mplier_next = {w_sum[0], r_mplier[DATA_W-1:1]};

    assign o_busy    = r_busy;
    assign o_count   = r_count;
    assign o_done    = r_busy && w_last && !i_hold && !i_abort;
    assign o_product = {w_acc_next[DATA_W-1:0], w_mplier_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (i_abort) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_mcand  <= {i_a[DATA_W-1], i_a};
            r_acc    <= '0;
            r_mplier <= i_b;
        end else if (r_busy && !i_hold) begin
            r_acc    <= w_acc_next;
            r_mplier <= w_mplier_next;
            if (w_last) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage: ALU, branch resolution, iterative mult into HI/LO, EX/MEM register.
// Define EX_FORWARD_EN to forward the EX/MEM result back into the A and rt operands.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int ADDR_W      = mips_pkg::ADDR_W,
    parameter int MULT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           RegDstIn,
    input  logic                           BranchIn,
    input  logic                           MemReadIn,
    input  logic                           MemtoRegIn,
    input  logic                           MemWriteIn,
    input  logic                           ALUSrcIn,
    input  logic                           RegWriteIn,
    input  logic [1:0]                     ALUOpIn,
    input  logic [ADDR_W-1:0]              addressIn,
    input  logic [DATA_W-1:0]              data1In,
    input  logic [DATA_W-1:0]              data2In,
    input  logic [DATA_W-1:0]              sign32In,
    input  logic [ADDR_W-1:0]              sign10In,
    input  logic [4:0]                     writeReg1In,
    input  logic [4:0]                     writeReg2In,
    input  logic [4:0]                     rsIn,
    input  logic                           mem_stall,
    input  logic                           flush,
    output logic                           stall_out,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              aluResultOut,
    output logic [DATA_W-1:0]              storeDataOut,
    output logic [4:0]                     writeRegOut,
    output logic                           MemReadOut,
    output logic                           MemWriteOut,
    output logic                           MemtoRegOut,
    output logic                           RegWriteOut,
    output logic                           BranchTakenOut,
    output logic [ADDR_W-1:0]              branchTargetOut,
    output ex_state_e                      o_dbg_state,
    output logic [$clog2(MULT_CYCLES)-1:0] o_dbg_count,
    output logic [DATA_W-1:0]              o_dbg_hi,
    output logic [DATA_W-1:0]              o_dbg_lo
);

    ex_state_e         r_state, w_state_next;
    logic [DATA_W-1:0] r_hi, r_lo;
    logic [4:0]        r_mult_dest;

    logic              r_valid, r_mem_read, r_mem_write, r_mem_to_reg, r_reg_write, r_branch_taken;
    logic [DATA_W-1:0] r_alu_result, r_store_data;
    logic [4:0]        r_write_reg;
    logic [ADDR_W-1:0] r_branch_target;

    logic              w_n_valid, w_n_mem_read, w_n_mem_write, w_n_mem_to_reg, w_n_reg_write, w_n_branch_taken;
    logic [DATA_W-1:0] w_n_alu_result, w_n_store_data;
    logic [4:0]        w_n_write_reg;
    logic [ADDR_W-1:0] w_n_branch_target;

    logic [DATA_W-1:0]   w_a, w_data2, w_b, w_diff, w_alu_result;
    logic [2*DATA_W-1:0] w_product;
    logic [5:0]          w_funct;
    logic [4:0]          w_shamt, w_dest;
    logic                w_is_mult, w_accept, w_start, w_alu_ok, w_zero, w_exmem_en;
    logic                w_mult_busy, w_mult_done;

`ifdef EX_FORWARD_EN
    logic w_fwd_ok;
    assign w_fwd_ok = r_valid && r_reg_write && (r_write_reg != 5'd0);
    assign w_a      = (w_fwd_ok && r_write_reg == rsIn)        ? r_alu_result : data1In;
    assign w_data2  = (w_fwd_ok && r_write_reg == writeReg1In) ? r_alu_result : data2In;
`else
    // Operand hazards are resolved by hazard-unit stalls upstream.
    logic w_unused_rs;
    assign w_unused_rs = ^rsIn;
    assign w_a         = data1In;
    assign w_data2     = data2In;
`endif

    assign w_b       = ALUSrcIn ? sign32In : w_data2;
    assign w_diff    = w_a - w_b;
    assign w_zero    = (w_diff == '0);
    assign w_funct   = sign32In[5:0];
    assign w_shamt   = sign32In[10:6];
    assign w_dest    = RegDstIn ? writeReg2In : writeReg1In;
    assign w_is_mult = (alu_op_e'(ALUOpIn) == ALUOP_RTYPE) && (w_funct == FUNCT_MULT);
    assign stall_out = mem_stall || (r_state == ST_MULT);
    assign w_accept  = in_valid && !stall_out;
    assign w_start   = w_accept && w_is_mult && !flush;

    always_comb begin
        w_alu_result = '0;
        w_alu_ok     = 1'b1;
        case (alu_op_e'(ALUOpIn))
            ALUOP_ADD: w_alu_result = w_a + w_b;
            ALUOP_SUB: w_alu_result = w_diff;
            ALUOP_OR:  w_alu_result = w_a | w_b;
            default: begin
                case (w_funct)
                    FUNCT_ADD:  w_alu_result = w_a + w_b;
                    FUNCT_SUB:  w_alu_result = w_diff;
                    FUNCT_AND:  w_alu_result = w_a & w_b;
                    FUNCT_OR:   w_alu_result = w_a | w_b;
                    FUNCT_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
                    FUNCT_SLL:  w_alu_result = w_b << w_shamt;
                    FUNCT_SRL:  w_alu_result = w_b >> w_shamt;
                    FUNCT_MFHI: w_alu_result = r_hi;
                    FUNCT_MFLO: w_alu_result = r_lo;
                    FUNCT_MULT: w_alu_result = '0;
                    default:    w_alu_ok     = 1'b0;
                endcase
            end
        endcase
    end

    ex_mult_iter #(
        .DATA_W      (DATA_W),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_hold    (mem_stall),
        .i_abort   (flush),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_busy    (w_mult_busy),
        .o_done    (w_mult_done),
        .o_count   (o_dbg_count),
        .o_product (w_product)
    );

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_IDLE) begin
            if (w_start) w_state_next = ST_MULT;
        end else begin
            if (flush || w_mult_done || !w_mult_busy) w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_mult_dest <= '0;
        end else begin
            if (w_mult_done) {r_hi, r_lo} <= w_product;
            if (w_start)     r_mult_dest  <= w_dest;
        end
    end

    // The mult entry carries LO as its result; it never writes the register file.
    always_comb begin
        w_n_valid         = 1'b0;
        w_n_mem_read      = 1'b0;
        w_n_mem_write     = 1'b0;
        w_n_mem_to_reg    = 1'b0;
        w_n_reg_write     = 1'b0;
        w_n_branch_taken  = 1'b0;
        w_n_alu_result    = '0;
        w_n_store_data    = '0;
        w_n_write_reg     = '0;
        w_n_branch_target = '0;
        if (flush) begin
            w_n_valid = 1'b0;
        end else if (r_state == ST_MULT) begin
            if (w_mult_done) begin
                w_n_valid      = 1'b1;
                w_n_alu_result = w_product[DATA_W-1:0];
                w_n_write_reg  = r_mult_dest;
            end
        end else begin
            w_n_alu_result    = w_alu_result;
            w_n_store_data    = w_data2;
            w_n_write_reg     = w_dest;
            w_n_branch_target = addressIn + sign10In;
            if (in_valid && !w_is_mult) begin
                w_n_valid        = 1'b1;
                w_n_mem_read     = MemReadIn;
                w_n_mem_write    = MemWriteIn;
                w_n_mem_to_reg   = MemtoRegIn;
                w_n_reg_write    = RegWriteIn && w_alu_ok;
                w_n_branch_taken = BranchIn && w_zero;
            end
        end
    end

    assign w_exmem_en = flush || !mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_write_reg     <= '0;
            r_branch_target <= '0;
        end else if (w_exmem_en) begin
            r_valid         <= w_n_valid;
            r_mem_read      <= w_n_mem_read;
            r_mem_write     <= w_n_mem_write;
            r_mem_to_reg    <= w_n_mem_to_reg;
            r_reg_write     <= w_n_reg_write;
            r_branch_taken  <= w_n_branch_taken;
            r_alu_result    <= w_n_alu_result;
            r_store_data    <= w_n_store_data;
            r_write_reg     <= w_n_write_reg;
            r_branch_target <= w_n_branch_target;
        end
    end

    assign out_valid       = r_valid;
    assign aluResultOut    = r_alu_result;
    assign storeDataOut    = r_store_data;
    assign writeRegOut     = r_write_reg;
    assign MemReadOut      = r_mem_read;
    assign MemWriteOut     = r_mem_write;
    assign MemtoRegOut     = r_mem_to_reg;
    assign RegWriteOut     = r_reg_write;
    assign BranchTakenOut  = r_branch_taken;
    assign branchTargetOut = r_branch_target;
    assign o_dbg_state     = r_state;
    assign o_dbg_hi        = r_hi;
    assign o_dbg_lo        = r_lo;

endmodule
